// File: rtl/reg_file_tagged.sv
// Architectural register file with per-register busy bit and pending ROB tag.
// Issue allocates a producer tag, commit writes data and releases a matching tag.
module reg_file_tagged #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned TAGW = 4,
    parameter int unsigned NRD  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic                 cm_en,
    input  logic [AW-1:0]        cm_rd,
    input  logic [TAGW-1:0]      cm_tag,
    input  logic [XLEN-1:0]      cm_data,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAGW-1:0]  rd_tag,
    output logic [AW:0]          busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0][XLEN-1:0] data_q;
    logic [NREG-1:0][TAGW-1:0] tag_q;
    logic [NREG-1:0]           busy_q;

    logic iss_wr;
    logic cm_wr;
    logic cm_clr;
    logic cnt_inc;
    logic cnt_dec;

    // Write qualifiers; x0 is never written, and issue overrides a same-register release.
    always_comb begin
        iss_wr  = iss_en && (iss_rd != '0) && !flush;
        cm_wr   = cm_en && (cm_rd != '0);
        cm_clr  = cm_wr && busy_q[cm_rd] && (tag_q[cm_rd] == cm_tag);
        cnt_inc = iss_wr && !busy_q[iss_rd];
        cnt_dec = cm_clr && !(iss_wr && (iss_rd == cm_rd));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            tag_q    <= '0;
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            if (cm_wr) begin
                data_q[cm_rd] <= cm_data;
            end
            if (flush) begin
                busy_q   <= '0;
                busy_cnt <= '0;
            end else begin
                if (cm_clr) begin
                    busy_q[cm_rd] <= 1'b0;
                end
                if (iss_wr) begin
                    busy_q[iss_rd] <= 1'b1;
                    tag_q[iss_rd]  <= iss_tag;
                end
                busy_cnt <= busy_cnt + CW'(cnt_inc) - CW'(cnt_dec);
            end
        end
    end

    // Read ports: commit data bypass, busy released early on a matching commit tag.
    always_comb begin
        logic [AW-1:0] a;
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        a       = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            if (!rst && (a != '0)) begin
                rd_tag[k*TAGW +: TAGW] = tag_q[a];
                if (cm_en && (cm_rd == a)) begin
                    rd_data[k*XLEN +: XLEN] = cm_data;
                    rd_busy[k]              = busy_q[a] && (tag_q[a] != cm_tag);
                end else begin
                    rd_data[k*XLEN +: XLEN] = data_q[a];
                    rd_busy[k]              = busy_q[a];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_tagged.sv
// Directed testbench for reg_file_tagged: issue/commit/flush/x0/reset scenarios.
module tb_reg_file_tagged;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [3:0]  iss_tag;
    logic        cm_en;
    logic [4:0]  cm_rd;
    logic [3:0]  cm_tag;
    logic [31:0] cm_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic [5:0]  busy_cnt;

    int n_pass;
    int n_total;

    reg_file_tagged #(.XLEN(32), .NREG(32), .AW(5), .TAGW(4), .NRD(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_en(iss_en), .iss_rd(iss_rd), .iss_tag(iss_tag),
        .cm_en(cm_en), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_data(cm_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .rd_tag(rd_tag), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle();
        flush  = 1'b0;
        iss_en = 1'b0; iss_rd = '0; iss_tag = '0;
        cm_en  = 1'b0; cm_rd  = '0; cm_tag  = '0; cm_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] r, input logic [3:0] t);
        iss_en = 1'b1; iss_rd = r; iss_tag = t;
    endtask

    task automatic do_commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
        cm_en = 1'b1; cm_rd = r; cm_tag = t; cm_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); rd_addr = {5'd3, 5'd0};
        #3;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d want 0", busy_cnt); else n_pass++;
        n_total++; if (rd_data !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'd0)
            $display("FAIL reset_reads: data %h busy %b tag %h want all 0", rd_data, rd_busy, rd_tag); else n_pass++;
        #10 rst = 1'b0;
        tick();
    endtask

    task automatic test_issue_commit();
        rd_addr = {5'd0, 5'd3};
        do_issue(5'd3, 4'd7); tick(); idle(); #1;
        n_total++; if (rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd7)
            $display("FAIL ic_issued: busy %b tag %0d want 1 7", rd_busy[0], rd_tag[3:0]); else n_pass++;
        n_total++; if (busy_cnt !== 6'd1) $display("FAIL ic_cnt1: got %0d want 1", busy_cnt); else n_pass++;
        do_commit(5'd3, 4'd7, 32'hDEADBEEF); #1;
        n_total++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
            $display("FAIL ic_bypass: data %h busy %b want deadbeef 0", rd_data[31:0], rd_busy[0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b0)
            $display("FAIL ic_array: data %h busy %b want deadbeef 0", rd_data[31:0], rd_busy[0]); else n_pass++;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL ic_cnt0: got %0d want 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_stale_commit();
        rd_addr = {5'd0, 5'd3};
        do_issue(5'd3, 4'd2); tick();
        do_issue(5'd3, 4'd5); tick(); idle();
        do_commit(5'd3, 4'd2, 32'h11); tick(); idle(); #1;
        n_total++; if (rd_data[31:0] !== 32'h11 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd5)
            $display("FAIL stale_read: data %h busy %b tag %0d want 11 1 5", rd_data[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
        n_total++; if (busy_cnt !== 6'd1) $display("FAIL stale_cnt: got %0d want 1", busy_cnt); else n_pass++;
        do_commit(5'd3, 4'd5, 32'h12); tick(); idle(); #1;
        n_total++; if (busy_cnt !== 6'd0 || rd_busy[0] !== 1'b0)
            $display("FAIL stale_release: cnt %0d busy %b want 0 0", busy_cnt, rd_busy[0]); else n_pass++;
    endtask

    task automatic test_issue_commit_same_cycle();
        rd_addr = {5'd4, 5'd4};
        do_issue(5'd4, 4'd1); tick(); idle();
        do_commit(5'd4, 4'd1, 32'h22); do_issue(5'd4, 4'd9); #1;
        n_total++; if (rd_data[31:0] !== 32'h22 || rd_busy[0] !== 1'b0 || rd_tag[3:0] !== 4'd1)
            $display("FAIL same_cyc_read: data %h busy %b tag %0d want 22 0 1", rd_data[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data[31:0] !== 32'h22 || rd_busy[0] !== 1'b1 || rd_tag[3:0] !== 4'd9)
            $display("FAIL same_cyc_next: data %h busy %b tag %0d want 22 1 9", rd_data[31:0], rd_busy[0], rd_tag[3:0]); else n_pass++;
        n_total++; if (busy_cnt !== 6'd1) $display("FAIL same_cyc_cnt: got %0d want 1", busy_cnt); else n_pass++;
        do_commit(5'd4, 4'd9, 32'h23); tick(); idle(); #1;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL same_cyc_release: got %0d want 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        do_issue(5'd1, 4'd1); tick();
        do_issue(5'd2, 4'd2); tick();
        do_issue(5'd3, 4'd3); tick(); idle(); #1;
        n_total++; if (busy_cnt !== 6'd3) $display("FAIL flush_pre_cnt: got %0d want 3", busy_cnt); else n_pass++;
        rd_addr = {5'd6, 5'd2};
        flush = 1'b1; do_issue(5'd6, 4'd6); do_commit(5'd2, 4'd9, 32'h33); #1;
        n_total++; if (rd_data[31:0] !== 32'h33 || rd_busy !== 2'b01 || rd_tag[3:0] !== 4'd2)
            $display("FAIL flush_same_cyc: data %h busy %b tag %0d want 33 01 2", rd_data[31:0], rd_busy, rd_tag[3:0]); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data[31:0] !== 32'h33 || rd_busy !== 2'b00 || rd_tag[3:0] !== 4'd2)
            $display("FAIL flush_after: data %h busy %b tag %0d want 33 00 2", rd_data[31:0], rd_busy, rd_tag[3:0]); else n_pass++;
        rd_addr = {5'd3, 5'd1}; #1;
        n_total++; if (rd_busy !== 2'b00) $display("FAIL flush_x1x3: busy %b want 00", rd_busy); else n_pass++;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL flush_cnt: got %0d want 0", busy_cnt); else n_pass++;
    endtask

    task automatic test_x0_multiport();
        rd_addr = {5'd0, 5'd0};
        do_issue(5'd0, 4'd5); do_commit(5'd0, 4'd5, 32'hFF); #1;
        n_total++; if (rd_data !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'd0)
            $display("FAIL x0_same_cyc: data %h busy %b tag %h want 0", rd_data, rd_busy, rd_tag); else n_pass++;
        tick(); idle(); #1;
        n_total++; if (rd_data !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'd0)
            $display("FAIL x0_after: data %h busy %b tag %h want 0", rd_data, rd_busy, rd_tag); else n_pass++;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL x0_cnt: got %0d want 0", busy_cnt); else n_pass++;
        do_issue(5'd7, 4'hB); tick(); idle();
        rd_addr = {5'd7, 5'd7}; #1;
        n_total++; if (rd_busy !== 2'b11 || rd_tag !== 8'hBB)
            $display("FAIL mp_same_reg: busy %b tag %h want 11 bb", rd_busy, rd_tag); else n_pass++;
        rd_addr = {5'd7, 5'd2}; #1;
        n_total++; if (rd_data[31:0] !== 32'h33 || rd_busy !== 2'b10 || rd_tag !== 8'hB2)
            $display("FAIL mp_distinct: data0 %h busy %b tag %h want 33 10 b2", rd_data[31:0], rd_busy, rd_tag); else n_pass++;
    endtask

    task automatic test_back_to_back();
        rd_addr = {5'd31, 5'd30};
        do_issue(5'd31, 4'hF); tick();
        do_issue(5'd30, 4'hE); tick(); idle(); #1;
        n_total++; if (busy_cnt !== 6'd3) $display("FAIL b2b_cnt3: got %0d want 3", busy_cnt); else n_pass++;
        do_commit(5'd31, 4'hF, 32'hFFFFFFFF); tick();
        do_commit(5'd30, 4'hE, 32'h30303030); tick(); idle(); #1;
        n_total++; if (rd_data !== {32'hFFFFFFFF, 32'h30303030} || rd_busy !== 2'b00)
            $display("FAIL b2b_data: data %h busy %b want ffffffff30303030 00", rd_data, rd_busy); else n_pass++;
        n_total++; if (busy_cnt !== 6'd1) $display("FAIL b2b_cnt1: got %0d want 1", busy_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_commit(5'd5, 4'd0, 32'hAA); tick(); idle();
        do_issue(5'd5, 4'd3); tick(); idle(); #1;
        n_total++; if (busy_cnt !== 6'd2) $display("FAIL rstmid_pre_cnt: got %0d want 2", busy_cnt); else n_pass++;
        rd_addr = {5'd7, 5'd5};
        do_commit(5'd5, 4'd3, 32'h55);
        #2 rst = 1'b1; #1;
        n_total++; if (busy_cnt !== 6'd0) $display("FAIL rstmid_cnt: got %0d want 0", busy_cnt); else n_pass++;
        n_total++; if (rd_data !== 64'd0 || rd_busy !== 2'b00 || rd_tag !== 8'd0)
            $display("FAIL rstmid_reads: data %h busy %b tag %h want 0", rd_data, rd_busy, rd_tag); else n_pass++;
        tick(); idle(); #2 rst = 1'b0; #1;
        n_total++; if (rd_data[31:0] !== 32'd0 || rd_busy !== 2'b00)
            $display("FAIL rstmid_after: data %h busy %b want 0 00", rd_data[31:0], rd_busy); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rd_addr = '0;
        test_reset();
        test_issue_commit();
        test_stale_commit();
        test_issue_commit_same_cycle();
        test_flush();
        test_x0_multiport();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
